// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: walks phases 1..NUM_PHASES per instruction, idles at phase 0.
// Optional completed-instruction counter is built only when INSTR_COUNT_EN is defined.
module phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int PHASE_W    = 3,
  parameter int PC_PHASE   = 5,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exec_req,
  input  logic               hlt,
  input  logic               stall,
  input  logic               step_mode,
  output logic [PHASE_W-1:0] phase,
  output logic               executing,
  output logic               pc_e,
  output logic               instr_done,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count
);

  if ((NUM_PHASES < 2) || (NUM_PHASES > (2 ** PHASE_W) - 1)) begin : g_bad_num_phases
    $error("phase_sequencer: NUM_PHASES=%0d does not fit PHASE_W=%0d", NUM_PHASES, PHASE_W);
  end
  if ((PC_PHASE < 1) || (PC_PHASE > NUM_PHASES)) begin : g_bad_pc_phase
    $error("phase_sequencer: PC_PHASE=%0d outside 1..%0d", PC_PHASE, NUM_PHASES);
  end

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES);
  localparam logic [PHASE_W-1:0] PC_PH      = PHASE_W'(PC_PHASE);
  localparam logic [PHASE_W-1:0] ONE_PH     = PHASE_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               stop_q, stop_d;
  logic               hpend_q, hpend_d;
  logic               halted_q, halted_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      stop_q   <= 1'b0;
      hpend_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      stop_q   <= stop_d;
      hpend_q  <= hpend_d;
      halted_q <= halted_d;
    end
  end

  // Stop requests are latched during the instruction and only honoured at its last phase.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    stop_d   = stop_q;
    hpend_d  = hpend_q;
    halted_d = halted_q;
    case (state_q)
      IDLE: begin
        if (exec_req) begin
          state_d  = RUN;
          phase_d  = ONE_PH;
          stop_d   = 1'b0;
          hpend_d  = 1'b0;
          halted_d = 1'b0;
        end else begin
          phase_d  = '0;
        end
      end
      RUN: begin
        stop_d  = stop_q | exec_req | hlt;
        hpend_d = hpend_q | hlt;
        if (stall) begin
          phase_d = phase_q;
        end else if (phase_q != LAST_PHASE) begin
          phase_d = phase_q + ONE_PH;
        end else if (stop_q | exec_req | hlt | step_mode) begin
          state_d  = IDLE;
          phase_d  = '0;
          halted_d = hpend_q | hlt;
          stop_d   = 1'b0;
          hpend_d  = 1'b0;
        end else begin
          phase_d  = ONE_PH;
          stop_d   = 1'b0;
          hpend_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  assign phase      = phase_q;
  assign executing  = (state_q == RUN);
  assign halted     = halted_q;
  assign pc_e       = (phase_q == PC_PH) & ~stall;
  assign instr_done = (phase_q == LAST_PHASE) & ~stall;

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (instr_done) begin
      count_q <= count_q + CNT_W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: vector table with an expectation queue, plus hand sequences.
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        exec_req, hlt, stall, step_mode;
  logic [2:0]  phase;
  logic        executing, pc_e, instr_done, halted;
  logic [31:0] instr_count;

  logic        er2, zero2;
  logic [2:0]  phase2;
  logic        executing2, pc_e2, done2, halted2;
  logic [3:0]  count2;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int exp_cnt   = 0;

  always #5 clk = ~clk;

  phase_sequencer dut (
    .clk(clk), .rst(rst), .exec_req(exec_req), .hlt(hlt), .stall(stall), .step_mode(step_mode),
    .phase(phase), .executing(executing), .pc_e(pc_e), .instr_done(instr_done),
    .halted(halted), .instr_count(instr_count)
  );

  phase_sequencer #(.NUM_PHASES(7), .PHASE_W(3), .PC_PHASE(2), .CNT_W(4)) dut7 (
    .clk(clk), .rst(rst), .exec_req(er2), .hlt(zero2), .stall(zero2), .step_mode(zero2),
    .phase(phase2), .executing(executing2), .pc_e(pc_e2), .instr_done(done2),
    .halted(halted2), .instr_count(count2)
  );

  typedef struct {
    logic       er, h, st, sm;
    logic       pc, dn;
    logic [2:0] ph;
    logic       hl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] cnt_exp(input int n, input int w);
`ifdef INSTR_COUNT_EN
    logic [63:0] m;
    m = 64'(n) & ((64'd1 << w) - 64'd1);
    return m;
`else
    return 64'd0;
`endif
  endfunction

  task automatic add(input logic er, h, st, sm, pc, dn, input logic [2:0] ph, input logic hl);
    vec_t v;
    v.er = er; v.h = h; v.st = st; v.sm = sm; v.pc = pc; v.dn = dn; v.ph = ph; v.hl = hl;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic er, h, st, sm);
    exec_req = er; hlt = h; stall = st; step_mode = sm;
  endtask

  initial begin
    vec_t v, e;
    int   len, waited;
    logic [2:0] exp_ph;

    rst = 1'b1; er2 = 1'b0; zero2 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // fields: exec_req hlt stall step_mode | pc_e instr_done (before edge) | phase halted (after edge)
    add(1,0,0,0, 0,0, 3'd1, 0);
    add(0,0,0,0, 0,0, 3'd2, 0);
    add(0,0,0,0, 0,0, 3'd3, 0);
    add(0,0,0,0, 0,0, 3'd4, 0);
    add(0,0,0,0, 0,0, 3'd5, 0);
    add(0,0,0,0, 1,1, 3'd1, 0);
    add(0,0,0,0, 0,0, 3'd2, 0);
    add(0,1,0,0, 0,0, 3'd3, 0);
    add(0,0,0,0, 0,0, 3'd4, 0);
    add(0,0,0,0, 0,0, 3'd5, 0);
    add(0,0,0,0, 1,1, 3'd0, 1);
    add(0,0,0,0, 0,0, 3'd0, 1);
    add(1,0,0,0, 0,0, 3'd1, 0);
    add(0,0,0,0, 0,0, 3'd2, 0);
    add(0,0,0,0, 0,0, 3'd3, 0);
    for (int i = 0; i < 4; i++) add(0,0,1,0, 0,0, 3'd3, 0);
    add(0,0,0,0, 0,0, 3'd4, 0);
    add(0,0,0,0, 0,0, 3'd5, 0);
    add(0,0,1,0, 0,0, 3'd5, 0);
    add(1,0,0,0, 1,1, 3'd0, 0);
    add(0,0,0,0, 0,0, 3'd0, 0);
    add(1,0,0,1, 0,0, 3'd1, 0);
    add(0,0,0,1, 0,0, 3'd2, 0);
    add(0,0,0,1, 0,0, 3'd3, 0);
    add(0,0,0,1, 0,0, 3'd4, 0);
    add(0,0,0,1, 0,0, 3'd5, 0);
    add(0,0,0,1, 1,1, 3'd0, 0);
    add(1,0,0,0, 0,0, 3'd1, 0);
    add(1,0,0,0, 0,0, 3'd2, 0);
    add(0,0,0,0, 0,0, 3'd3, 0);
    add(0,0,0,0, 0,0, 3'd4, 0);
    add(0,0,0,0, 0,0, 3'd5, 0);
    add(0,0,0,0, 1,1, 3'd0, 0);
    add(1,0,0,0, 0,0, 3'd1, 0);
    add(0,1,1,0, 0,0, 3'd1, 0);
    add(0,0,0,0, 0,0, 3'd2, 0);
    add(0,0,0,0, 0,0, 3'd3, 0);
    add(0,0,0,0, 0,0, 3'd4, 0);
    add(0,0,0,0, 0,0, 3'd5, 0);
    add(0,0,0,0, 1,1, 3'd0, 1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_exec", 64'(executing), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_pc_e", 64'(pc_e), 64'd0);
    chk("rst_done", 64'(instr_done), 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);
    rst = 1'b0;

    // Table: drive at negedge, check combinational outputs, queue post-edge expectations
    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.er, v.h, v.st, v.sm);
      #1;
      chk($sformatf("vec%0d_pc_e", i), 64'(pc_e), 64'(v.pc));
      chk($sformatf("vec%0d_done", i), 64'(instr_done), 64'(v.dn));
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.dn) exp_cnt++;
      chk($sformatf("vec%0d_phase", i), 64'(phase), 64'(e.ph));
      chk($sformatf("vec%0d_exec", i), 64'(executing), 64'(e.ph != 3'd0));
      chk($sformatf("vec%0d_halted", i), 64'(halted), 64'(e.hl));
      chk($sformatf("vec%0d_count", i), 64'(instr_count), cnt_exp(exp_cnt, 32));
    end

    // Single-step: three pulses 10 cycles apart, each run exactly 5 cycles
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      len = 0;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        exec_req = 1'b0;
        if (executing) len++;
      end
      chk($sformatf("step%0d_len", r), 64'(len), 64'd5);
      chk($sformatf("step%0d_idle", r), 64'(phase), 64'd0);
      chk($sformatf("step%0d_halted", r), 64'(halted), 64'd0);
    end
    exp_cnt += 3;
    chk("step_count", 64'(instr_count), cnt_exp(exp_cnt, 32));

    // Asynchronous reset at phase 4 abandons the instruction
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exec_req = 1'b0;
    waited = 0;
    while (phase != 3'd4 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_reach_ph4", 64'(phase), 64'd4);
    #2 rst = 1'b1;
    #1;
    chk("arst_phase", 64'(phase), 64'd0);
    chk("arst_exec", 64'(executing), 64'd0);
    chk("arst_done", 64'(instr_done), 64'd0);
    chk("arst_pc_e", 64'(pc_e), 64'd0);
    chk("arst_count", 64'(instr_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    len = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (instr_done) len++;
    end
    chk("arst_no_done", 64'(len), 64'd0);
    chk("arst_stay_idle", 64'(phase), 64'd0);

    // Seven-phase instance: PC at phase 2, 16 instructions wrap a 4-bit counter
    @(negedge clk);
    er2 = 1'b1;
    @(negedge clk);
    er2 = 1'b0;
    for (int k = 0; k < 112; k++) begin
      exp_ph = 3'((k % 7) + 1);
      chk($sformatf("p7_phase%0d", k), 64'(phase2), 64'(exp_ph));
      chk($sformatf("p7_pc_e%0d", k), 64'(pc_e2), 64'(exp_ph == 3'd2));
      chk($sformatf("p7_done%0d", k), 64'(done2), 64'(exp_ph == 3'd7));
      if (k == 105) chk("p7_count15", 64'(count2), cnt_exp(15, 4));
      if (k == 111) er2 = 1'b1;
      @(negedge clk);
    end
    er2 = 1'b0;
    chk("p7_stopped", 64'(phase2), 64'd0);
    chk("p7_exec_low", 64'(executing2), 64'd0);
    chk("p7_count_wrap", 64'(count2), cnt_exp(16, 4));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
